// File: rtl/calc_pkg.sv
// Shared definitions for the calculator engine: operand width, opcodes,
// state encoding, default display codes and the display formatting helper.
// Ports: none (package).
package calc_pkg;

  localparam int OPW = 14;
  localparam logic [OPW-1:0] MAX_VAL = 14'd9999;
  localparam logic [OPW-1:0] ENTRY_LIMIT = 14'd1000;

  localparam logic [3:0] DEF_BLANK_CODE = 4'hF;
  localparam logic [3:0] DEF_ERR_CODE   = 4'hE;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  typedef enum logic [2:0] {
    ST_ENTRY_A = 3'd0,
    ST_ENTRY_B = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_CONVERT = 3'd3,
    ST_RESULT  = 3'd4,
    ST_ERROR   = 3'd5
  } state_e;

  // Turns four BCD digits {d4,d3,d2,d1} into display codes, replacing
  // leading zeros with the blank code. The units digit is never blanked,
  // so zero shows as a single "0".
  function automatic logic [15:0] disp_fmt(input logic [15:0] bcd,
                                           input logic [3:0]  blank);
    logic [15:0] d;
    logic        lead;
    d    = bcd;
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && (bcd[4*i +: 4] == 4'd0)) begin
        d[4*i +: 4] = blank;
      end else begin
        lead = 1'b0;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Sequential double-dabble: 14-bit binary to four BCD digits.
// Latency: i_start sampled on edge 0, o_done pulses for the cycle after edge 13,
// so a consumer reacting to o_done leaves on edge 14. No backpressure; a new
// i_start restarts the conversion.
// Ports: clk, reset (async high), i_start, i_bin[13:0], o_done, o_bcd[15:0] = {d4,d3,d2,d1}.
module calc_bin2bcd
  import calc_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           i_start,
  input  logic [OPW-1:0] i_bin,
  output logic           o_done,
  output logic [15:0]    o_bcd
);

  logic [OPW+15:0] r_sh;   // {bcd[15:0], binary[13:0]}
  logic [3:0]      r_cnt;
  logic            r_run;
  logic            r_done;

  // One iteration: adjust each BCD column that is >= 5, then shift left.
  function automatic logic [OPW+15:0] dd_step(input logic [OPW+15:0] v);
    logic [OPW+15:0] t;
    t = v;
    for (int d = 0; d < 4; d++) begin
      if (t[OPW + 4*d +: 4] >= 4'd5) begin
        t[OPW + 4*d +: 4] = t[OPW + 4*d +: 4] + 4'd3;
      end
    end
    return t << 1;
  endfunction

  // The load edge already performs the first iteration (the BCD field is
  // zero, so it is a plain shift); 13 more follow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_sh  <= dd_step({16'd0, i_bin});
        r_cnt <= 4'd1;
        r_run <= 1'b1;
      end else if (r_run) begin
        r_sh  <= dd_step(r_sh);
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt == 4'd13) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_bcd  = r_sh[OPW+15:OPW];

endmodule

// File: rtl/calc_engine.sv
// Four-digit keypad calculator: operand entry, add/sub/mul (1 cycle),
// restoring div/mod (14 cycles), BCD conversion (14 cycles), display drive.
// Latency: display updates one cycle after an accepted key; busy 15 cycles
// for add/sub/mul, 28 for div/mod. Key pulses arriving while busy are dropped.
// Ports: clk, reset (async high), num[3:0]/numPressed, opt[2:0]/optPressed,
// submit; outputs num1..num4 (num1 rightmost), busy, err.
module calc_engine
  import calc_pkg::*;
#(
  parameter logic [3:0] BLANK_CODE = DEF_BLANK_CODE,
  parameter logic [3:0] ERR_CODE   = DEF_ERR_CODE
)(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] num,
  input  logic       numPressed,
  input  logic [2:0] opt,
  input  logic       optPressed,
  input  logic       submit,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic [3:0] num4,
  output logic       busy,
  output logic       err
);

  state_e         r_state, w_state_nx;
  logic [OPW-1:0] r_acc, w_acc_nx;
  logic [15:0]    r_acc_bcd, w_acc_bcd_nx;  // acc kept in BCD too, for display
  logic [OPW-1:0] r_a, w_a_nx;
  logic [OPW-1:0] r_b, w_b_nx;
  logic [2:0]     r_op, w_op_nx;
  logic [3:0]     r_cnt, w_cnt_nx;
  logic [OPW-1:0] r_rem, w_rem_nx;
  logic [OPW-1:0] r_quo, w_quo_nx;
  logic [OPW-1:0] r_result, w_result_nx;
  logic [15:0]    r_disp, w_disp_nx;        // {num4,num3,num2,num1}

  // One event per cycle: submit beats operator beats digit.
  logic w_ev_sub, w_ev_opt, w_ev_num;
  logic w_op_ok, w_dig_ok, w_acc_room;
  logic [OPW-1:0] w_acc_dig;
  logic [15:0]    w_acc_bcd_dig;

  assign w_ev_sub      = submit;
  assign w_ev_opt      = !submit && optPressed;
  assign w_ev_num      = !submit && !optPressed && numPressed;
  assign w_op_ok       = (opt <= OP_MOD);
  assign w_dig_ok      = (num <= 4'd9);
  assign w_acc_room    = (r_acc < ENTRY_LIMIT);
  assign w_acc_dig     = r_acc * 14'd10 + {10'd0, num};
  assign w_acc_bcd_dig = {r_acc_bcd[11:0], num};

  // Arithmetic
  logic [OPW:0]     w_sum;
  logic [2*OPW-1:0] w_prod;
  logic [OPW:0]     w_div_shift;
  logic             w_div_ge;
  logic [OPW-1:0]   w_div_rem, w_div_quo;
  logic [OPW-1:0]   w_alu_res;
  logic             w_alu_err, w_alu_last;

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_prod = {14'd0, r_a} * {14'd0, r_b};

  // Restoring divide step: bring down the next dividend bit, subtract the
  // divisor when it fits. The remainder stays below B, so 14 bits suffice.
  assign w_div_shift = {r_rem, r_quo[OPW-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
  assign w_div_rem   = w_div_ge ? 14'(w_div_shift - {1'b0, r_b}) : w_div_shift[OPW-1:0];
  assign w_div_quo   = {r_quo[OPW-2:0], w_div_ge};

  always_comb begin
    w_alu_res  = w_sum[OPW-1:0];
    w_alu_err  = 1'b0;
    w_alu_last = 1'b1;
    case (r_op)
      OP_ADD: begin
        w_alu_res = w_sum[OPW-1:0];
        w_alu_err = (w_sum > {1'b0, MAX_VAL});
      end
      OP_SUB: begin
        w_alu_res = r_a - r_b;
        w_alu_err = (r_a < r_b);
      end
      OP_MUL: begin
        w_alu_res = w_prod[OPW-1:0];
        w_alu_err = (w_prod > {14'd0, MAX_VAL});
      end
      OP_DIV, OP_MOD: begin
        // Iteration 14 is taken combinationally into the converter start.
        w_alu_res  = (r_op == OP_DIV) ? w_div_quo : w_div_rem;
        w_alu_err  = (r_b == '0);
        w_alu_last = (r_cnt == 4'd13);
      end
      default: w_alu_err = 1'b1;
    endcase
  end

  logic           w_cvt_start;
  logic [OPW-1:0] w_cvt_bin;
  logic           w_cvt_done;
  logic [15:0]    w_cvt_bcd;

  calc_bin2bcd u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_cvt_start),
    .i_bin   (w_cvt_bin),
    .o_done  (w_cvt_done),
    .o_bcd   (w_cvt_bcd)
  );

  always_comb begin
    w_state_nx   = r_state;
    w_acc_nx     = r_acc;
    w_acc_bcd_nx = r_acc_bcd;
    w_a_nx       = r_a;
    w_b_nx       = r_b;
    w_op_nx      = r_op;
    w_cnt_nx     = r_cnt;
    w_rem_nx     = r_rem;
    w_quo_nx     = r_quo;
    w_result_nx  = r_result;
    w_disp_nx    = r_disp;
    w_cvt_start  = 1'b0;
    w_cvt_bin    = '0;

    case (r_state)
      ST_ENTRY_A: begin
        // Display already shows acc, which becomes A: no display change.
        if (w_ev_opt && w_op_ok) begin
          w_a_nx       = r_acc;
          w_op_nx      = opt;
          w_acc_nx     = '0;
          w_acc_bcd_nx = '0;
          w_state_nx   = ST_ENTRY_B;
        end else if (w_ev_num && w_dig_ok && w_acc_room) begin
          w_acc_nx     = w_acc_dig;
          w_acc_bcd_nx = w_acc_bcd_dig;
          w_disp_nx    = disp_fmt(w_acc_bcd_dig, BLANK_CODE);
        end
      end

      ST_ENTRY_B: begin
        // Display keeps showing A until a digit of B is taken.
        if (w_ev_sub) begin
          w_b_nx     = r_acc;
          w_cnt_nx   = '0;
          w_rem_nx   = '0;
          w_quo_nx   = r_a;
          w_state_nx = ST_COMPUTE;
        end else if (w_ev_opt && w_op_ok) begin
          w_op_nx = opt;
        end else if (w_ev_num && w_dig_ok && w_acc_room) begin
          w_acc_nx     = w_acc_dig;
          w_acc_bcd_nx = w_acc_bcd_dig;
          w_disp_nx    = disp_fmt(w_acc_bcd_dig, BLANK_CODE);
        end
      end

      ST_COMPUTE: begin
        if (w_alu_err) begin
          w_state_nx = ST_ERROR;
          w_disp_nx  = {BLANK_CODE, BLANK_CODE, BLANK_CODE, ERR_CODE};
        end else if (w_alu_last) begin
          w_result_nx = w_alu_res;
          w_cvt_start = 1'b1;
          w_cvt_bin   = w_alu_res;
          w_state_nx  = ST_CONVERT;
        end else begin
          w_rem_nx = w_div_rem;
          w_quo_nx = w_div_quo;
          w_cnt_nx = r_cnt + 4'd1;
        end
      end

      ST_CONVERT: begin
        if (w_cvt_done) begin
          w_disp_nx  = disp_fmt(w_cvt_bcd, BLANK_CODE);
          w_state_nx = ST_RESULT;
        end
      end

      ST_RESULT: begin
        // Display shows the result, which becomes A when chaining.
        if (w_ev_opt && w_op_ok) begin
          w_a_nx       = r_result;
          w_op_nx      = opt;
          w_acc_nx     = '0;
          w_acc_bcd_nx = '0;
          w_state_nx   = ST_ENTRY_B;
        end else if (w_ev_num && w_dig_ok) begin
          w_acc_nx     = {10'd0, num};
          w_acc_bcd_nx = {12'd0, num};
          w_disp_nx    = disp_fmt({12'd0, num}, BLANK_CODE);
          w_state_nx   = ST_ENTRY_A;
        end
      end

      ST_ERROR: begin
        if (w_ev_sub) begin
          w_acc_nx     = '0;
          w_acc_bcd_nx = '0;
          w_disp_nx    = disp_fmt(16'd0, BLANK_CODE);
          w_state_nx   = ST_ENTRY_A;
        end else if (w_ev_num && w_dig_ok) begin
          w_acc_nx     = {10'd0, num};
          w_acc_bcd_nx = {12'd0, num};
          w_disp_nx    = disp_fmt({12'd0, num}, BLANK_CODE);
          w_state_nx   = ST_ENTRY_A;
        end
      end

      default: w_state_nx = ST_ENTRY_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_ENTRY_A;
      r_acc     <= '0;
      r_acc_bcd <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= OP_ADD;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_result  <= '0;
      r_disp    <= {BLANK_CODE, BLANK_CODE, BLANK_CODE, 4'd0};
    end else begin
      r_state   <= w_state_nx;
      r_acc     <= w_acc_nx;
      r_acc_bcd <= w_acc_bcd_nx;
      r_a       <= w_a_nx;
      r_b       <= w_b_nx;
      r_op      <= w_op_nx;
      r_cnt     <= w_cnt_nx;
      r_rem     <= w_rem_nx;
      r_quo     <= w_quo_nx;
      r_result  <= w_result_nx;
      r_disp    <= w_disp_nx;
    end
  end

  assign {num4, num3, num2, num1} = r_disp;
  assign busy = (r_state == ST_COMPUTE) || (r_state == ST_CONVERT);
  assign err  = (r_state == ST_ERROR);

endmodule

// File: tb/tb_calc_engine.sv
`timescale 1ns/1ps
module tb_calc_engine;

  localparam logic [3:0] BL = 4'hF;
  localparam logic [3:0] ER = 4'hE;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] num = 4'd0;
  logic       numPressed = 1'b0;
  logic [2:0] opt = 3'd0;
  logic       optPressed = 1'b0;
  logic       submit = 1'b0;
  logic [3:0] num1, num2, num3, num4;
  logic       busy, err;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  calc_engine #(.BLANK_CODE(BL), .ERR_CODE(ER)) dut (
    .clk(clk), .reset(reset), .num(num), .numPressed(numPressed),
    .opt(opt), .optPressed(optPressed), .submit(submit),
    .num1(num1), .num2(num2), .num3(num3), .num4(num4),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam int M_A = 0, M_B = 1, M_BUSY = 2, M_RES = 3, M_ERR = 4;
  int m_mode = M_A, m_acc = 0, m_a = 0, m_b = 0, m_op = 0;
  int m_res = 0, m_dv = 0, m_left = 0;
  bit m_err = 1'b0;

  function automatic logic [15:0] fmt(input int v);
    logic [15:0] d;
    d[3:0]   = 4'(v % 10);
    d[7:4]   = (v < 10)   ? BL : 4'((v / 10) % 10);
    d[11:8]  = (v < 100)  ? BL : 4'((v / 100) % 10);
    d[15:12] = (v < 1000) ? BL : 4'(v / 1000);
    return d;
  endfunction

  function automatic logic [17:0] exp_vec();
    if (m_mode == M_ERR) return {1'b0, 1'b1, BL, BL, BL, ER};
    return {(m_mode == M_BUSY), 1'b0, fmt(m_dv)};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {busy, err, num4, num3, num2, num1};
  endfunction

  function automatic logic [17:0] lit(input bit b, input bit e,
      input logic [3:0] d4, input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1);
    return {b, e, d4, d3, d2, d1};
  endfunction

  task automatic model_compute();
    case (m_op)
      0: begin m_res = m_a + m_b; m_err = (m_res > 9999); end
      1: begin m_err = (m_a < m_b); m_res = m_a - m_b; end
      2: begin m_res = m_a * m_b; m_err = (m_res > 9999); end
      3: begin m_err = (m_b == 0); m_res = m_err ? 0 : m_a / m_b; end
      default: begin m_err = (m_b == 0); m_res = m_err ? 0 : m_a % m_b; end
    endcase
    m_left = m_err ? 1 : ((m_op >= 3) ? 28 : 15);
  endtask

  task automatic model_step();
    bit dig;
    dig = numPressed && (int'(num) <= 9);
    case (m_mode)
      M_A: if (!submit) begin
        if (optPressed) begin
          if (int'(opt) <= 4) begin m_a = m_acc; m_op = int'(opt); m_acc = 0; m_mode = M_B; end
        end else if (dig && m_acc < 1000) begin
          m_acc = m_acc * 10 + int'(num); m_dv = m_acc;
        end
      end
      M_B: begin
        if (submit) begin
          m_b = m_acc; model_compute(); m_mode = M_BUSY;
        end else if (optPressed) begin
          if (int'(opt) <= 4) m_op = int'(opt);
        end else if (dig && m_acc < 1000) begin
          m_acc = m_acc * 10 + int'(num); m_dv = m_acc;
        end
      end
      M_BUSY: begin
        m_left--;
        if (m_left == 0) begin
          if (m_err) m_mode = M_ERR;
          else begin m_mode = M_RES; m_dv = m_res; end
        end
      end
      M_RES: if (!submit) begin
        if (optPressed) begin
          if (int'(opt) <= 4) begin m_a = m_res; m_op = int'(opt); m_acc = 0; m_mode = M_B; end
        end else if (dig) begin
          m_acc = int'(num); m_dv = m_acc; m_mode = M_A;
        end
      end
      default: begin
        if (submit) begin m_acc = 0; m_dv = 0; m_mode = M_A; end
        else if (!optPressed && dig) begin m_acc = int'(num); m_dv = m_acc; m_mode = M_A; end
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_mode = M_A; m_acc = 0; m_a = 0; m_b = 0; m_op = 0;
      m_res = 0; m_dv = 0; m_left = 0; m_err = 1'b0;
    end else begin
      model_step();
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      n_assert++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t dut=%h expected=%h", $time, dut_vec(), exp_vec());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic press(input bit s, input bit o, input bit n,
                       input logic [2:0] ov, input logic [3:0] nv);
    @(posedge clk); #2;
    submit = s; optPressed = o; numPressed = n; opt = ov; num = nv;
    @(posedge clk); #2;
    submit = 1'b0; optPressed = 1'b0; numPressed = 1'b0; opt = 3'd0; num = 4'd0;
  endtask

  task automatic k(input logic [3:0] d);   press(1'b0, 1'b0, 1'b1, 3'd0, d); endtask
  task automatic op(input logic [2:0] o);  press(1'b0, 1'b1, 1'b0, o, 4'd0); endtask
  task automatic eq();                     press(1'b1, 1'b0, 1'b0, 3'd0, 4'd0); endtask

  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
  endtask

  task automatic check_lit(input string name, input logic [17:0] expv);
    @(negedge clk);
    n_assert++;
    if (dut_vec() !== expv) begin
      n_fail++;
      $display("FAIL %s dut=%h expected=%h", name, dut_vec(), expv);
    end
    n_assert++;
    if (exp_vec() !== expv) begin
      n_fail++;
      $display("FAIL %s_model model=%h expected=%h", name, exp_vec(), expv);
    end
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) return;
      cnt++;
    end
    n_assert++; n_fail++;
    $display("FAIL busy_timeout busy still high after %0d cycles, expected low", cnt);
  endtask

  task automatic check_cnt(input string name, input int got, input int expv);
    n_assert++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, expected finish before 200000ns");
    $fatal(1);
  end

  initial begin
    int c;
    #1 reset = 1'b1;
    chk_en = 1'b1;
    check_lit("reset_state", lit(0, 0, BL, BL, BL, 4'd0));
    @(posedge clk); #2 reset = 1'b0;

    // 12 + 34 = 46
    k(4'd1); check_lit("entry_1", lit(0, 0, BL, BL, BL, 4'd1));
    k(4'd2); check_lit("entry_12", lit(0, 0, BL, BL, 4'd1, 4'd2));
    op(3'd0); check_lit("show_a", lit(0, 0, BL, BL, 4'd1, 4'd2));
    k(4'd3); check_lit("entry_b_first", lit(0, 0, BL, BL, BL, 4'd3));
    k(4'd4); eq();
    wait_idle(c); check_cnt("add_busy_cycles", c, 15);
    check_lit("add_46", lit(0, 0, BL, BL, 4'd4, 4'd6));

    // 7 - 9 -> error, then key 5
    do_reset();
    k(4'd7); op(3'd1); k(4'd9); eq(); wait_idle(c);
    check_lit("sub_neg_err", lit(0, 1, BL, BL, BL, ER));
    k(4'd5); check_lit("err_then_5", lit(0, 0, BL, BL, BL, 4'd5));

    // 100 / 7 = 14, then mod 7 = 0
    do_reset();
    k(4'd1); k(4'd0); k(4'd0); op(3'd3); k(4'd7); eq();
    wait_idle(c); check_cnt("div_busy_cycles", c, 28);
    check_lit("div_14", lit(0, 0, BL, BL, 4'd1, 4'd4));
    op(3'd4); k(4'd7); eq();
    wait_idle(c); check_cnt("mod_busy_cycles", c, 28);
    check_lit("chain_mod_0", lit(0, 0, BL, BL, BL, 4'd0));

    // fifth digit dropped; overflow and divide-by-zero errors
    do_reset();
    k(4'd1); k(4'd2); k(4'd3); k(4'd4); k(4'd5);
    check_lit("five_digits", lit(0, 0, 4'd1, 4'd2, 4'd3, 4'd4));
    do_reset();
    k(4'hB); check_lit("bad_digit", lit(0, 0, BL, BL, BL, 4'd0));
    k(4'd9); k(4'd9); k(4'd9); k(4'd9); op(3'd6);
    op(3'd2); k(4'd2); eq(); wait_idle(c);
    check_lit("mul_ovf_err", lit(0, 1, BL, BL, BL, ER));
    k(4'd5); op(3'd3); k(4'd0); eq(); wait_idle(c);
    check_lit("div0_err", lit(0, 1, BL, BL, BL, ER));

    // same-cycle submit+digit; keys while busy are dropped
    do_reset();
    k(4'd6); op(3'd0); k(4'd2);
    press(1'b1, 1'b0, 1'b1, 3'd0, 4'd9);
    k(4'd3); op(3'd2); eq();
    wait_idle(c);
    check_lit("sub_beats_digit", lit(0, 0, BL, BL, BL, 4'd8));
    eq(); check_lit("result_submit_ignored", lit(0, 0, BL, BL, BL, 4'd8));
    op(3'd0); k(4'd1); eq(); wait_idle(c);
    check_lit("chain_add_9", lit(0, 0, BL, BL, BL, 4'd9));

    // upper boundary without error
    do_reset();
    k(4'd9); k(4'd9); k(4'd9); k(4'd8); op(3'd0); k(4'd1); eq(); wait_idle(c);
    check_lit("add_9999", lit(0, 0, 4'd9, 4'd9, 4'd9, 4'd9));

    // reset in the middle of a divide
    do_reset();
    k(4'd1); k(4'd0); k(4'd0); op(3'd3); k(4'd7); eq();
    repeat (7) @(negedge clk);
    #1 reset = 1'b1;
    check_lit("mid_div_reset", lit(0, 0, BL, BL, BL, 4'd0));
    @(posedge clk); #2 reset = 1'b0;
    k(4'd3); op(3'd0); k(4'd4); eq();
    wait_idle(c); check_cnt("post_reset_busy", c, 15);
    check_lit("post_reset_7", lit(0, 0, BL, BL, BL, 4'd7));

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_engine.md
CALC_ENGINE -- requirements
Module: calc_engine

Interface
REQ-001 Parameter BLANK_CODE, default 4'hF, digit code the display driver renders as unlit.
REQ-002 Parameter ERR_CODE, default 4'hE, digit code the display driver renders as "E".
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 num  input  4  digit code from the keypad decoder, valid only while numPressed=1.
REQ-006 numPressed  input  1  one-cycle pulse marking a digit key.
REQ-007 opt  input  3  operator code, valid only while optPressed=1: 0 add, 1 sub, 2 mul, 3 div, 4 mod; 5-7 reserved.
REQ-008 optPressed  input  1  one-cycle pulse marking an operator key.
REQ-009 submit  input  1  one-cycle pulse marking the "=" key.
REQ-010 num1..num4  output  4 each  display digit codes; num1 is the least-significant (rightmost) position.
REQ-011 busy  output  1  high while in COMPUTE or CONVERT.
REQ-012 err  output  1  high while in ERROR.

Function
REQ-013 States: ENTRY_A, ENTRY_B, COMPUTE, CONVERT, RESULT, ERROR.
REQ-014 Operands are unsigned binary values, 0..9999 (14 bits).
REQ-015 Digit entry: in ENTRY_A or ENTRY_B, numPressed with num<=9 and acc<1000 sets acc = acc*10 + num.
REQ-016 Digit entry is ignored when num>9 or when acc>=1000 (the fifth digit is dropped).
REQ-017 Same-cycle priority: submit > optPressed > numPressed; at most one event is acted on per cycle.
REQ-018 ENTRY_A with optPressed and a valid opcode: A=acc, op latched, acc=0, go ENTRY_B; reserved opcodes are ignored.
REQ-019 ENTRY_B with optPressed: op is replaced; submit: B=acc, go COMPUTE. In ENTRY_A, submit is ignored.
REQ-020 COMPUTE add/sub/mul takes 1 cycle.
REQ-021 COMPUTE div/mod is a 14-iteration restoring divider: 14 cycles, then CONVERT.
REQ-022 Error conditions: add or mul result >9999, sub with A<B, div or mod with B=0. On error go ERROR and skip CONVERT.
REQ-023 CONVERT: sequential double-dabble, 14 cycles, producing 4 BCD digits, then RESULT.
REQ-024 All numPressed/optPressed/submit pulses that arrive while busy=1 are dropped, not queued.
REQ-025 RESULT on numPressed: acc=num, go ENTRY_A.
REQ-026 RESULT on optPressed (valid opcode): A=result (chaining), acc=0, go ENTRY_B.
REQ-027 RESULT on submit: ignored.
REQ-028 ERROR on numPressed: acc=num, go ENTRY_A; on submit: acc=0, go ENTRY_A; optPressed is ignored.
REQ-029 Display in ENTRY_A: acc.
REQ-030 Display in ENTRY_B: A until the first digit of B is entered, then acc.
REQ-031 Display during COMPUTE/CONVERT: holds the previous value.
REQ-032 Display in RESULT: result.
REQ-033 Display in ERROR: num1=ERR_CODE, num2..num4=BLANK_CODE.
REQ-034 Leading zeros are shown as BLANK_CODE; a value of 0 shows "0" in num1.
REQ-035 Outputs are registered: display updates on the cycle after the accepted event.

Reset
REQ-036 Asserting reset at any time, including mid-divide or mid-convert, forces ENTRY_A, acc=A=B=0, op=add.
REQ-037 Reset output values: num1=0, num2..num4=BLANK_CODE, busy=0, err=0.
REQ-038 First event accepted after reset release: on the first clk edge with reset low.

Structure
REQ-039 Shared package calc_pkg holds:
- opcode constants,
- state encoding,
- BLANK_CODE and ERR_CODE defaults,
- the operand width constant (14).
REQ-040 Sub-module calc_bin2bcd: start/done handshake, 14-bit binary in, four 4-bit BCD digits out, fixed 14-cycle latency.
REQ-041 The divider is inline in calc_engine.

Verification
REQ-042 Keys 1,2,+,3,4,= -> busy for 15 cycles, then num2..num1=4,6, num4..num3 blank.
REQ-043 Keys 7,-,9,= -> err=1, num1=ERR_CODE, others blank; then key 5 -> err=0, num1=5.
REQ-044 Keys 1,0,0,/,7,= -> busy high 28 cycles, then display 14; then keys mod,7,= -> display 0 (chaining 14 mod 7).
REQ-045 Keys 1,2,3,4,5 -> display 1234; 9,9,9,9,*,2,= -> ERROR; 5,/,0,= -> ERROR.
REQ-046 Same-cycle submit and numPressed in ENTRY_B -> compute only, digit dropped; key during busy -> dropped.
REQ-047 Reset asserted on divide cycle 7 -> next cycle: busy=0, display "0"; subsequent 3,+,4,= -> 7.
